// File: rtl/logic_operand_queue.sv
// Operand buffer in front of the bitwise AND/OR unit: a first-word-fall-through
// FIFO of {x, a, b} entries with valid/ready handshakes on both sides.
module logic_operand_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_x,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     x,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic             x;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // in_ready ignores out_ready on purpose: a full queue never accepts,
    // even when the head is leaving in the same cycle.
    assign in_ready  = !full && !flush && rst_n;
    assign out_valid = !empty;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; stale contents are hidden by the output mask.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{x: in_x, a: in_a, b: in_b};
    end

    assign head = mem[rd_ptr];
    assign x    = out_valid & head.x;
    assign a    = head.a & {WIDTH{out_valid}};
    assign b    = head.b & {WIDTH{out_valid}};

endmodule

// File: tb/tb_logic_operand_queue.sv
// Self-checking bench for logic_operand_queue: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_logic_operand_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int VW    = 3 + 2 * WIDTH + CW;

    typedef struct packed {
        logic             x;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_x = 1'b0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             x;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CW-1:0]    count;
    logic [VW-1:0]    obs;

    int total = 0;
    int bad   = 0;
    entry_t q[$];

    logic_operand_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .a(a), .b(b), .count(count)
    );

    always #5 clk = ~clk;

    assign obs = {in_ready, out_valid, x, a, b, count};

    // Expected outputs from the model: the head of a plain queue, zero when empty.
    function automatic logic [VW-1:0] exp_vec();
        entry_t h;
        logic   rdy;
        h   = '0;
        if (q.size() > 0) h = q[0];
        rdy = (q.size() < DEPTH) && !flush && rst_n;
        return {rdy, (q.size() > 0), h, CW'(q.size())};
    endfunction

    // Apply the FIFO rules to the model for the current inputs, then clock once.
    task automatic tick();
        bit     do_push;
        entry_t e;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            do_push = in_valid && (q.size() < DEPTH);
            e = {in_x, in_a, in_b};
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic xs, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic rdy);
        in_valid  = v;
        in_x      = xs;
        in_a      = av;
        in_b      = bv;
        out_ready = rdy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        tick();
        #1; total++;
        if (obs !== {1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0}) begin
            bad++; $display("FAIL reset_hold got=%h exp=%h", obs, {1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0});
        end
        set_in(1'b0, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b1;
        #1; total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0}) begin
            bad++; $display("FAIL reset_release got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0});
        end
    endtask

    task automatic test_single();
        set_in(1'b1, 1'b1, 8'hF0, 8'h3C, 1'b0);
        tick();
        set_in(1'b0, 1'b0, '0, '0, 1'b0);
        #1; total++;
        if (obs !== {1'b1, 1'b1, 1'b1, 8'hF0, 8'h3C, 3'd1}) begin
            bad++; $display("FAIL single_visible got=%h exp=%h", obs, {1'b1, 1'b1, 1'b1, 8'hF0, 8'h3C, 3'd1});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1; total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0}) begin
            bad++; $display("FAIL single_popped got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0});
        end
    endtask

    task automatic test_fill_and_drain();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            set_in(1'b1, i[0], 8'(i), 8'(8'h80 + i), 1'b0);
            #1; total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL fill i=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            tick();
        end
        set_in(1'b0, 1'b0, '0, '0, 1'b1);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            #1; total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL drain i=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 1'b0, 8'(8'h10 + i), 8'(i), 1'b0);
            tick();
        end
        set_in(1'b1, 1'b1, 8'hAA, 8'h55, 1'b1);
        #1; total++;
        if (obs !== exp_vec() || in_ready !== 1'b0) begin
            bad++; $display("FAIL full_pushpop_ready got=%h exp=%h", obs, exp_vec());
        end
        tick();
        set_in(1'b0, 1'b0, '0, '0, 1'b1);
        #1; total++;
        if (obs !== exp_vec() || count !== 3'd3) begin
            bad++; $display("FAIL full_pushpop_count got=%h exp=%h", obs, exp_vec());
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            #1; total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL full_pushpop_drain i=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream_wrap();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, i[1], 8'(i), 8'(~i), 1'b1);
            #1; total++;
            if (obs !== exp_vec() || (i > 0 && count !== 3'd1)) begin
                bad++; $display("FAIL stream i=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            tick();
        end
        set_in(1'b0, 1'b0, '0, '0, 1'b1);
        tick();
        out_ready = 1'b0;
        #1; total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL stream_end got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 8'(8'h30 + i), 8'h0F, 1'b0);
            tick();
        end
        set_in(1'b1, 1'b0, 8'hEE, 8'hDD, 1'b1);
        flush = 1'b1;
        #1; total++;
        if (obs !== exp_vec() || in_ready !== 1'b0) begin
            bad++; $display("FAIL flush_during got=%h exp=%h", obs, exp_vec());
        end
        tick();
        flush = 1'b0;
        set_in(1'b0, 1'b0, '0, '0, 1'b0);
        #1; total++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0}) begin
            bad++; $display("FAIL flush_after got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0});
        end
        set_in(1'b1, 1'b0, 8'h5A, 8'hA5, 1'b0);
        tick();
        set_in(1'b0, 1'b0, '0, '0, 1'b1);
        #1; total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL flush_repush got=%h exp=%h", obs, exp_vec());
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b1, 8'(8'hC0 + i), 8'hFF, 1'b0);
            tick();
        end
        set_in(1'b0, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1; total++;
        if (obs !== exp_vec() || in_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_during got=%h exp=%h", obs, exp_vec());
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            #1; total++;
            if (obs !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0}) begin
                bad++; $display("FAIL rstmid_after i=%0d got=%h exp=%h", i, obs, {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0});
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 24) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            #1; total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random i=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            tick();
        end
        flush = 1'b0;
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_and_drain();
        test_full_push_pop();
        test_stream_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
